// File: rtl/img_hist_if.sv
`default_nettype none
// ============================================================================
//  Module      : img_hist_if
//  Description : AXI4-Stream video bundle shared by the histogram input/output.
//  Revision    : 1.0 - initial release
// ============================================================================
interface img_hist_if #(
    parameter int TDATA_WIDTH   = 16,
    parameter int TDATA_WIDTH_B = 2
);
    logic [TDATA_WIDTH-1:0]   tdata;
    logic [TDATA_WIDTH_B-1:0] tstrb;
    logic [TDATA_WIDTH_B-1:0] tkeep;
    logic                     tvalid;
    logic                     tready;
    logic                     tlast;
    logic                     tuser;
    logic                     tid;
    logic                     tdest;

    modport master (
        output tdata, tstrb, tkeep, tvalid, tlast, tuser, tid, tdest,
        input  tready
    );

    modport slave (
        input  tdata, tstrb, tkeep, tvalid, tlast, tuser, tid, tdest,
        output tready
    );
endinterface
`default_nettype wire

// File: rtl/img_hist.sv
`default_nettype none
// ============================================================================
//  Module      : img_hist
//  Description : Per-frame pixel histogram tap on a pass-through video stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module img_hist #(
    parameter int PX_WIDTH      = 10,
    parameter int TDATA_WIDTH   = 16,
    parameter int TDATA_WIDTH_B = 2,
    parameter int CNT_WIDTH     = 22
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_n_i,
    img_hist_if.slave                 video_i,
    img_hist_if.master                video_o,
    input  wire logic                 hist_en_i,
    input  wire logic                 hist_clear_i,
    output logic                      hist_valid_o,
    input  wire logic [PX_WIDTH-1:0]  hist_rd_addr_i,
    output logic [CNT_WIDTH-1:0]      hist_rd_data_o,
    output logic [CNT_WIDTH-1:0]      hist_px_cnt_o
);
    localparam logic [CNT_WIDTH-1:0] c_cnt_max  = '1;
    localparam logic [PX_WIDTH-1:0]  c_last_bin = '1;

    typedef enum logic [2:0] {
        S_CLEAR    = 3'd0,
        S_WAIT_SOF = 3'd1,
        S_ACCUM    = 3'd2,
        S_DRAIN    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_acc;
    logic                  w_sof;
    logic                  w_count;
    logic [PX_WIDTH-1:0]   w_px;
    logic [PX_WIDTH-1:0]   w_rd_addr;
    logic [PX_WIDTH-1:0]   r_clr_addr;
    logic [CNT_WIDTH-1:0]  r_px_cnt;
    logic [CNT_WIDTH-1:0]  r_rd_data;

    logic                  r_v1, r_v2, r_v3;
    logic [PX_WIDTH-1:0]   r_a1, r_a2, r_a3;
    logic [CNT_WIDTH-1:0]  r_d2, r_d3;
    logic [CNT_WIDTH-1:0]  w_base;
    logic [CNT_WIDTH-1:0]  w_inc;

    logic                  w_we;
    logic [PX_WIDTH-1:0]   w_wr_addr;
    logic [CNT_WIDTH-1:0]  w_wr_data;
    logic [CNT_WIDTH-1:0]  r_mem [0:(1<<PX_WIDTH)-1];

    assign video_o.tdata  = video_i.tdata;
    assign video_o.tstrb  = video_i.tstrb;
    assign video_o.tkeep  = video_i.tkeep;
    assign video_o.tvalid = video_i.tvalid;
    assign video_o.tlast  = video_i.tlast;
    assign video_o.tuser  = video_i.tuser;
    assign video_o.tid    = video_i.tid;
    assign video_o.tdest  = video_i.tdest;
    assign video_i.tready = video_o.tready;

    assign w_acc = video_i.tvalid & video_o.tready;
    assign w_sof = w_acc & video_i.tuser;
    assign w_px  = video_i.tdata[PX_WIDTH-1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_count     = 1'b0;
        case (r_state)
            S_CLEAR: begin
                if (r_clr_addr == c_last_bin) w_state_nxt = S_WAIT_SOF;
            end
            S_WAIT_SOF: begin
                if (w_sof && hist_en_i) begin
                    w_state_nxt = S_ACCUM;
                    w_count     = 1'b1;
                end
            end
            S_ACCUM: begin
                // tuser outranks tlast: only the next SOF closes the frame
                if (w_sof)      w_state_nxt = S_DRAIN;
                else if (w_acc) w_count     = 1'b1;
            end
            S_DRAIN: begin
                if (!r_v1 && !r_v2) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (hist_clear_i) w_state_nxt = S_CLEAR;
            end
            default: w_state_nxt = S_CLEAR;
        endcase
    end

    // Forward a value still in flight: stage 2 is about to be written, stage 3
    // was written on the same edge the stage-1 read was taken.
    always_comb begin
        w_base = r_rd_data;
        if (r_v2 && (r_a2 == r_a1))      w_base = r_d2;
        else if (r_v3 && (r_a3 == r_a1)) w_base = r_d3;
    end

    assign w_inc     = (w_base == c_cnt_max) ? w_base : w_base + 1'b1;
    assign w_rd_addr = (r_state == S_DONE) ? hist_rd_addr_i : w_px;

    assign w_we      = (r_state == S_CLEAR) | r_v2;
    assign w_wr_addr = (r_state == S_CLEAR) ? r_clr_addr : r_a2;
    assign w_wr_data = (r_state == S_CLEAR) ? '0 : r_d2;

    always_ff @(posedge clk_i) begin
        if (w_we) r_mem[w_wr_addr] <= w_wr_data;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_px_cnt   <= '0;
            r_rd_data  <= '0;
            r_v1       <= 1'b0;
            r_v2       <= 1'b0;
            r_v3       <= 1'b0;
            r_a1       <= '0;
            r_a2       <= '0;
            r_a3       <= '0;
            r_d2       <= '0;
            r_d3       <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_CLEAR) begin
                r_clr_addr <= r_clr_addr + 1'b1;
                r_px_cnt   <= '0;
            end else if (w_count && (r_px_cnt != c_cnt_max)) begin
                r_px_cnt <= r_px_cnt + 1'b1;
            end
            r_rd_data <= r_mem[w_rd_addr];
            r_v1      <= w_count;
            r_a1      <= w_px;
            r_v2      <= r_v1;
            r_a2      <= r_a1;
            r_d2      <= w_inc;
            r_v3      <= r_v2;
            r_a3      <= r_a2;
            r_d3      <= r_d2;
        end
    end

    assign hist_valid_o   = (r_state == S_DONE);
    assign hist_rd_data_o = r_rd_data;
    assign hist_px_cnt_o  = r_px_cnt;

endmodule
`default_nettype wire

// File: tb/tb_img_hist.sv
`default_nettype none
// ============================================================================
//  Module      : tb_img_hist
//  Description : Self-checking bench for img_hist (full-width and 4-bit-count DUTs).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_img_hist;
    localparam int PXW  = 10;
    localparam int TDW  = 16;
    localparam int TDWB = 2;
    localparam int CW   = 22;
    localparam int CWS  = 4;
    localparam int NB   = 1 << PXW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [TDW-1:0]  s_tdata;
    logic [TDWB-1:0] s_tstrb, s_tkeep;
    logic            s_tvalid, s_tlast, s_tuser, s_tid, s_tdest, s_ready;
    logic            hist_en, hist_clear;
    logic [PXW-1:0]  rd_addr;
    logic            valid_a, valid_b;
    logic [CW-1:0]   rd_a, px_a;
    logic [CWS-1:0]  rd_b, px_b;

    int n_cmp = 0;
    int n_bad = 0;
    int model [NB];
    int model_total;

    img_hist_if #(.TDATA_WIDTH(TDW), .TDATA_WIDTH_B(TDWB)) vi_a();
    img_hist_if #(.TDATA_WIDTH(TDW), .TDATA_WIDTH_B(TDWB)) vo_a();
    img_hist_if #(.TDATA_WIDTH(TDW), .TDATA_WIDTH_B(TDWB)) vi_b();
    img_hist_if #(.TDATA_WIDTH(TDW), .TDATA_WIDTH_B(TDWB)) vo_b();

    assign vi_a.tdata = s_tdata;   assign vi_b.tdata = s_tdata;
    assign vi_a.tstrb = s_tstrb;   assign vi_b.tstrb = s_tstrb;
    assign vi_a.tkeep = s_tkeep;   assign vi_b.tkeep = s_tkeep;
    assign vi_a.tvalid = s_tvalid; assign vi_b.tvalid = s_tvalid;
    assign vi_a.tlast = s_tlast;   assign vi_b.tlast = s_tlast;
    assign vi_a.tuser = s_tuser;   assign vi_b.tuser = s_tuser;
    assign vi_a.tid = s_tid;       assign vi_b.tid = s_tid;
    assign vi_a.tdest = s_tdest;   assign vi_b.tdest = s_tdest;
    assign vo_a.tready = s_ready;  assign vo_b.tready = s_ready;

    img_hist #(.PX_WIDTH(PXW), .TDATA_WIDTH(TDW), .TDATA_WIDTH_B(TDWB), .CNT_WIDTH(CW)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .video_i(vi_a), .video_o(vo_a),
        .hist_en_i(hist_en), .hist_clear_i(hist_clear), .hist_valid_o(valid_a),
        .hist_rd_addr_i(rd_addr), .hist_rd_data_o(rd_a), .hist_px_cnt_o(px_a)
    );

    img_hist #(.PX_WIDTH(PXW), .TDATA_WIDTH(TDW), .TDATA_WIDTH_B(TDWB), .CNT_WIDTH(CWS)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .video_i(vi_b), .video_o(vo_b),
        .hist_en_i(hist_en), .hist_clear_i(hist_clear), .hist_valid_o(valid_b),
        .hist_rd_addr_i(rd_addr), .hist_rd_data_o(rd_b), .hist_px_cnt_o(px_b)
    );

    typedef struct {
        logic [PXW-1:0] addr;
        int             exp;
    } rd_vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int satv(input int v, input int w);
        return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pass();
        chk("passthru",
            {vo_a.tdata, vo_a.tstrb, vo_a.tkeep, vo_a.tvalid, vo_a.tlast,
             vo_a.tuser, vo_a.tid, vo_a.tdest, vi_a.tready},
            {s_tdata, s_tstrb, s_tkeep, s_tvalid, s_tlast,
             s_tuser, s_tid, s_tdest, s_ready});
    endtask

    task automatic randomize_bus();
        s_tdata = TDW'($urandom);
        s_tstrb = TDWB'($urandom);
        s_tkeep = TDWB'($urandom);
        s_tlast = 1'($urandom);
        s_tuser = 1'($urandom);
        s_tid   = 1'($urandom);
        s_tdest = 1'($urandom);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            randomize_bus();
            s_tvalid = 1'b0;
            s_ready  = 1'($urandom);
            tick();
        end
    endtask

    // Non-accepted cycles carry garbage (including tuser) to prove it is ignored.
    task automatic send_beat(input logic [PXW-1:0] px, input logic sof, input int stall);
        logic acc;
        acc = 1'b0;
        for (int g = 0; g < 1000 && !acc; g++) begin
            randomize_bus();
            s_tvalid = ($urandom_range(0, 99) >= stall);
            s_ready  = ($urandom_range(0, 99) >= stall);
            acc      = s_tvalid & s_ready;
            if (acc) begin
                s_tdata[PXW-1:0] = px;
                s_tuser = sof;
            end
            #1 chk_pass();
            tick();
        end
        s_tvalid = 1'b0;
        if (!acc) chk("beat_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_frame(input int q[$], input int stall);
        for (int i = 0; i < q.size(); i++) send_beat(PXW'(q[i]), (i == 0), stall);
        send_beat(PXW'($urandom), 1'b1, stall);
        idle(2);
    endtask

    task automatic set_model(input int q[$]);
        for (int i = 0; i < NB; i++) model[i] = 0;
        foreach (q[i]) model[q[i]]++;
        model_total = q.size();
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 50 && !valid_a; i++) tick();
        chk({nm, "_valid"}, {valid_a, valid_b}, 2'b11);
    endtask

    task automatic read_bin(input int addr, output logic [CW-1:0] a, output logic [CWS-1:0] b);
        rd_addr = PXW'(addr);
        tick();
        a = rd_a;
        b = rd_b;
    endtask

    task automatic check_all(input string nm);
        logic [CW-1:0]  a;
        logic [CWS-1:0] b;
        int             sum;
        sum = 0;
        for (int i = 0; i < NB; i++) begin
            read_bin(i, a, b);
            sum += int'(a);
            chk($sformatf("%s_bin%0d", nm, i), a, satv(model[i], CW));
            chk($sformatf("%s_sat_bin%0d", nm, i), b, satv(model[i], CWS));
        end
        chk({nm, "_sum"}, sum, model_total);
        chk({nm, "_pxcnt"}, px_a, satv(model_total, CW));
        chk({nm, "_sat_pxcnt"}, px_b, satv(model_total, CWS));
    endtask

    task automatic do_clear(input string nm);
        chk({nm, "_valid_before"}, valid_a, 1'b1);
        hist_clear = 1'b1;
        tick();
        hist_clear = 1'b0;
        chk({nm, "_valid_fall"}, valid_a, 1'b0);
        idle(1030);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rd_vec_t        tbl [8];
        int             q[$];
        logic [CW-1:0]  a;
        logic [CWS-1:0] b;

        tbl[0] = '{10'd0, 1};    tbl[1] = '{10'd1, 1};
        tbl[2] = '{10'd2, 1};    tbl[3] = '{10'd3, 4};
        tbl[4] = '{10'd1023, 1}; tbl[5] = '{10'd4, 0};
        tbl[6] = '{10'd512, 0};  tbl[7] = '{10'd1022, 0};

        randomize_bus();
        s_tvalid = 1'b0; s_ready = 1'b0;
        hist_en = 1'b1; hist_clear = 1'b0; rd_addr = '0;

        // Reset: outputs idle, stream still passes through
        for (int i = 0; i < 4; i++) begin
            randomize_bus();
            s_tvalid = 1'($urandom); s_ready = 1'($urandom);
            #1 chk_pass();
            tick();
        end
        chk("rst_valid", {valid_a, valid_b}, 2'b00);
        chk("rst_pxcnt", px_a, 0);
        chk("rst_rddata", {rd_a, rd_b}, 0);
        rst_n = 1'b1;
        idle(1030);

        // Directed 4x2 frame, table-driven read-back
        q = '{0, 1, 2, 3, 3, 3, 3, 1023};
        send_frame(q, 0);
        wait_done("frameA");
        chk("frameA_pxcnt", px_a, 8);
        foreach (tbl[i]) begin
            read_bin(tbl[i].addr, a, b);
            chk($sformatf("frameA_bin%0d", tbl[i].addr), a, tbl[i].exp);
        end
        do_clear("clrA");

        // Back-to-back same bin
        q = {};
        for (int i = 0; i < 64; i++) q.push_back(5);
        send_frame(q, 0);
        set_model(q);
        wait_done("same5");
        check_all("same5");
        do_clear("clr5");

        // Alternating bins: exercises the one-gap forwarding path
        q = {};
        for (int i = 0; i < 64; i++) q.push_back((i % 2) ? 7 : 5);
        send_frame(q, 0);
        set_model(q);
        wait_done("alt57");
        check_all("alt57");
        do_clear("clr57");

        // Saturation on the 4-bit-count instance
        q = {};
        for (int i = 0; i < 20; i++) q.push_back(9);
        send_frame(q, 0);
        set_model(q);
        wait_done("sat");
        read_bin(9, a, b);
        chk("sat_bin9_full", a, 20);
        chk("sat_bin9_sat", b, 15);
        chk("sat_pxcnt_sat", px_b, 15);
        check_all("sat");

        // Traffic while DONE must not disturb the held result
        q = {};
        for (int i = 0; i < 50; i++) q.push_back(int'($urandom_range(0, NB - 1)));
        send_frame(q, 30);
        chk("done_hold_valid", valid_a, 1'b1);
        check_all("donehold");
        do_clear("clrS");

        // Random frame with random stalls on both sides
        q = {};
        for (int i = 0; i < 6000; i++)
            q.push_back(($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 3))
                                                     : int'($urandom_range(0, NB - 1)));
        send_frame(q, 30);
        set_model(q);
        wait_done("rand");
        check_all("rand");
        do_clear("clrR");

        // Asynchronous reset in the middle of a frame
        send_beat(10'd100, 1'b1, 0);
        for (int i = 0; i < 20; i++) send_beat(PXW'($urandom), 1'b0, 0);
        chk("pre_rst_pxcnt", px_a, 21);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pxcnt", px_a, 0);
        chk("async_rst_valid", valid_a, 1'b0);
        tick();
        rst_n = 1'b1;
        hist_en = 1'b0;
        idle(1030);

        // A frame arriving while disarmed is not counted
        q = {};
        for (int i = 0; i < 30; i++) q.push_back(int'($urandom_range(0, NB - 1)));
        send_frame(q, 10);
        idle(10);
        chk("disarmed_valid", valid_a, 1'b0);
        chk("disarmed_pxcnt", px_a, 0);

        hist_en = 1'b1;
        q = {};
        for (int i = 0; i < 100; i++) q.push_back(int'($urandom_range(0, NB - 1)));
        send_frame(q, 20);
        set_model(q);
        wait_done("postrst");
        check_all("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/img_hist.md
Name: img_hist

Overview:
- Per-frame pixel-value histogram collector on the AXI4-Stream video path, directly upstream of the LUT stage.
- Video passes through unchanged with zero added latency and no backpressure of its own.
- The block counts one complete frame into a 2^PX_WIDTH-bin RAM, then holds the result for firmware to read.
- Firmware builds the next LUT image (e.g. histogram equalisation) from the held result.

Parameters:
PX_WIDTH, 10, pixel bits; taken from tdata[PX_WIDTH-1:0]; bins = 2^PX_WIDTH
TDATA_WIDTH, 16, stream data width
TDATA_WIDTH_B, 2, tstrb/tkeep width
CNT_WIDTH, 22, bin counter and total pixel counter width

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
video_i_tdata/tstrb/tkeep  in  TDATA_WIDTH/TDATA_WIDTH_B/TDATA_WIDTH_B  input stream
video_i_tvalid/tlast/tuser/tid/tdest  in  1 each  input stream sideband (tuser = start of frame)
video_i_tready  out  1  equals video_o_tready
video_o_*  out  same widths  copies of video_i_* (combinational)
video_o_tready  in  1  downstream ready
hist_en_i  in  1  arm collection of the next frame
hist_clear_i  in  1  one-cycle pulse; releases held result
hist_valid_o  out  1  held histogram complete and readable
hist_rd_addr_i  in  PX_WIDTH  bin read address
hist_rd_data_o  out  CNT_WIDTH  bin count, 1-cycle read latency
hist_px_cnt_o  out  CNT_WIDTH  pixels counted in held frame

Behaviour:
- Accepted beat ("acc"): video_i_tvalid & video_o_tready.
- All video_o_* = video_i_* at all times, including in reset. The block never gates tready.
- FSM states: CLEAR, WAIT_SOF, ACCUM, DRAIN, DONE.
- Reset: asynchronous entry to CLEAR. hist_valid_o=0, hist_px_cnt_o=0, hist_rd_data_o=0, clear address=0. A reset mid-frame discards all counts.
- CLEAR: write 0 to bins 0..2^PX_WIDTH-1, one per cycle (2^PX_WIDTH cycles). Also zero the pixel counter. On the last bin go to WAIT_SOF.
- WAIT_SOF: no counting. On acc & tuser & hist_en_i go to ACCUM; that SOF beat is counted as the first pixel.
- ACCUM: every acc increments bin[tdata[PX_WIDTH-1:0]] and the pixel counter.
  - The next acc & tuser ends the frame: go to DRAIN. That beat is not counted.
  - hist_en_i is ignored while in ACCUM.
- RMW pipeline for bin increments:
  - Stage 0: issue RAM read at the pixel address.
  - Stage 1: RAM data returns.
  - Stage 2: write data+1.
  - Back-to-back accepted beats to the same bin, or with one gap, forward the in-flight value. Every beat is counted exactly; throughput is 1 beat/clock.
- Saturation: bin counts and the pixel counter saturate at 2^CNT_WIDTH-1 and never wrap.
- DRAIN: wait until the RMW pipeline is empty (at most 3 cycles), then go to DONE.
- DONE:
  - hist_valid_o=1 and hist_px_cnt_o holds the frame total.
  - A read of hist_rd_addr_i in cycle N gives hist_rd_data_o in cycle N+1.
  - Stream traffic is ignored.
  - On hist_clear_i: hist_valid_o=0 the next cycle, then go to CLEAR.
- hist_clear_i outside DONE is ignored.
- hist_rd_data_o outside DONE is don't-care. hist_px_cnt_o holds its last value until CLEAR zeroes it.
- tuser and tlast on the same beat: tuser takes priority; tlast is not used for frame delimiting.
- tvalid without tready: no count; beat data may change freely.

Test Plan:
- Reset, hist_en_i=1, wait for CLEAR, then a 4x2 frame with pixels 0,1,2,3,3,3,3,1023 followed by a SOF beat -> DONE; bins 0=1, 1=1, 2=1, 3=4, 1023=1, others 0; hist_px_cnt_o=8.
- 64 back-to-back accepted beats all =5, then SOF -> bin5=64 (checks forwarding). Repeat with an alternating 5,7 pattern -> bin5=32, bin7=32.
- Random tvalid and video_o_tready over a 1920x1080 random frame -> bins match the scoreboard; sum of bins = hist_px_cnt_o = 2073600; video_o always equal to video_i.
- CNT_WIDTH=4 with 20 beats of value 9 -> bin9=15 and hist_px_cnt_o=15 (saturated).
- In DONE, new frames on the input leave counts unchanged. hist_clear_i -> hist_valid_o falls next cycle; after 1024 CLEAR cycles, all bins read 0 on the next collection.
- Assert rst_n_i mid-ACCUM -> hist_valid_o=0 immediately; the next full frame counts only its own pixels. A frame starting with hist_en_i=0 is not counted.
